div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage initiator for the iterative divider: accepts DIV/DIVU requests from EX and holds operands stable in registers for the whole operation.
- Drives the divider start/ready handshake and stalls the pipeline while the divider works.
- Delivers remainder/quotient as a single HI/LO write, and drains a divide cancelled by a flush so the divider always returns to idle cleanly.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in RUN/DRAIN without div_ready_i before abort.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
ex_div_req_i  in  1  EX holds a divide instruction (level, held while stalled)
ex_div_signed_i  in  1  1=DIV, 0=DIVU
ex_opdata1_i  in  32  dividend
ex_opdata2_i  in  32  divisor
flush_i  in  1  exception/branch flush of EX
stall_hold_i  in  1  later stage stalls; EX instruction may not retire this cycle
stallreq_o  out  1  pipeline stall request
div_start_o  out  1  divider start (1=start, 0=stop), registered
div_signed_o  out  1  registered
div_opdata1_o  out  32  registered
div_opdata2_o  out  32  registered
div_result_i  in  64  {remainder, quotient}
div_ready_i  in  1  divider result valid
hi_o  out  32  remainder for HI
lo_o  out  32  quotient for LO
whilo_o  out  1  HI/LO write enable
timeout_o  out  1  sticky abort flag

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - div_start_o, div_signed_o, whilo_o, timeout_o = 0.
  - div_opdata*, hi_o, lo_o = 0.
  - Wait counter = 0.
- States: IDLE, RUN, DONE, DRAIN.
- IDLE:
  - ex_div_req_i=1 and flush_i=0: latch signed/opdata1/opdata2 into div_* registers; div_start_o<=1; counter<=0; ->RUN.
  - stallreq_o = ex_div_req_i & ~flush_i (combinational).
- RUN:
  - div_start_o and div_* held constant; operands from EX are ignored (forwarded values may change).
  - stallreq_o=1; counter increments each cycle.
  - div_ready_i=1 and flush_i=0: hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0], div_start_o<=0; ->DONE.
  - flush_i=1 (with or without ready) ->DRAIN. If ready is also present, div_start_o<=0, result discarded, ->IDLE directly.
  - counter reaches TIMEOUT_CYCLES: timeout_o<=1, div_start_o<=0; ->IDLE.
- DONE:
  - stallreq_o=0; hi_o/lo_o stable.
  - whilo_o = ~stall_hold_i & ~flush_i (combinational).
  - stall_hold_i=1 and flush_i=0: stay in DONE (no write).
  - Otherwise ->IDLE. Exactly one whilo_o cycle per completed divide.
- DRAIN:
  - div_start_o held 1 (divider ignores stop until it finishes).
  - stallreq_o = ex_div_req_i (a new divide waits); flush_i is ignored.
  - div_ready_i=1: div_start_o<=0, result discarded; ->IDLE.
  - Timeout rule as in RUN.
- Handshake invariants:
  - div_start_o is low for at least one full cycle after any cycle with div_ready_i=1 before it is reasserted. This is guaranteed by registered start plus the pass through IDLE.
  - div_* are constant whenever div_start_o=1.
- Results:
  - Divide-by-zero completes normally; the divider returns 0 and hi_o=lo_o=0 is written.
  - Sign correction is the divider's job; this block passes the result through.
- Divider latency is not assumed; the block waits for div_ready_i.
- timeout_o clears only on reset. The block stays functional after a timeout.
- div_ready_i while in IDLE or DONE is ignored.

Test Plan:
- DIVU 100/7, no stalls -> stallreq_o high from request until ready; then one whilo_o cycle with hi_o=2, lo_o=14; div_start_o low the cycle after ready.
- DIV 0xFFFFFFF9/2 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; div_opdata* unchanged even though ex_opdata1_i toggles during RUN.
- DIVU 0xFFFFFFFF/0x10 with stall_hold_i=1 for 3 cycles in DONE -> whilo_o=0 for those 3 cycles, then exactly one cycle of whilo_o=1 with hi_o=0xF, lo_o=0x0FFFFFFF.
- Divide by zero (opdata2=0) -> completes; whilo_o=1 with hi_o=lo_o=0.
- flush_i mid-RUN, new DIV request next cycle -> DRAIN: start held, stallreq_o=1, no whilo_o. After ready: start low ≥1 cycle, new divide issued, correct result written.
- Divider model never asserts ready -> timeout_o=1 after 64 cycles; start low; state IDLE. Async rst mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// EX-stage issue/stall control for an iterative divider: freezes operands for the
// whole divide, delivers {remainder, quotient} as one HI/LO write, drains flushed divides.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_req_i,
  input  logic        ex_div_signed_i,
  input  logic [31:0] ex_opdata1_i,
  input  logic [31:0] ex_opdata2_i,
  input  logic        flush_i,
  input  logic        stall_hold_i,
  output logic        stallreq_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        whilo_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          busy, issue, capture, abort, stop;

  // Divider handshake: div_start_o rises to launch an operation and div_* stay frozen
  // while it is high; the divider answers with a one-cycle div_ready_i, after which
  // div_start_o drops and stays low for at least one cycle before the next launch.
  assign busy    = (state == RUN) || (state == DRAIN);
  assign abort   = busy && !div_ready_i && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign issue   = (state == IDLE) && ex_div_req_i && !flush_i;
  assign capture = (state == RUN) && div_ready_i && !flush_i;
  assign stop    = busy && (div_ready_i || abort);
  assign state_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A ready in the same cycle as a flush needs no drain: the divider is already done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (issue) state_nxt = RUN;
      RUN: begin
        if (div_ready_i)  state_nxt = flush_i ? IDLE : DONE;
        else if (abort)   state_nxt = IDLE;
        else if (flush_i) state_nxt = DRAIN;
      end
      DONE:  if (!(stall_hold_i && !flush_i)) state_nxt = IDLE;
      DRAIN: if (div_ready_i || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = 1'b0;
    case (state)
      IDLE:  stallreq_o = ex_div_req_i && !flush_i;
      RUN:   stallreq_o = 1'b1;
      DONE:  whilo_o    = !stall_hold_i && !flush_i;
      DRAIN: stallreq_o = ex_div_req_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_start_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      hi_o          <= '0;
      lo_o          <= '0;
      timeout_o     <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      if (issue) begin
        div_signed_o  <= ex_div_signed_i;
        div_opdata1_o <= ex_opdata1_i;
        div_opdata2_o <= ex_opdata2_i;
        div_start_o   <= 1'b1;
        wait_cnt      <= '0;
      end else if (busy) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (stop) div_start_o <= 1'b0;
      if (capture) begin
        hi_o <= div_result_i[63:32];
        lo_o <= div_result_i[31:0];
      end
      if (abort) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Randomized bench for div_issue_ctrl: behavioural divider responder plus a
// transaction-level scoreboard of expected {remainder, quotient} writes.
module tb_div_issue_ctrl;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_req, ex_signed, flush, stall_hold;
  logic [31:0] ex_op1, ex_op2;
  logic        stallreq_o, div_start_o, div_signed_o, whilo_o, timeout_o;
  logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
  logic [63:0] div_result;
  logic        div_ready;
  logic [1:0]  state_o;

  logic [63:0] exp_q[$];
  logic [63:0] last_hilo;
  int          n_chk = 0;
  int          n_err = 0;

  // divider responder state
  bit          dm_busy, dm_hang, dm_wait_low;
  int          dm_cnt, dm_lat;
  logic [63:0] dm_res;

  div_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_div_req_i(ex_req), .ex_div_signed_i(ex_signed),
    .ex_opdata1_i(ex_op1), .ex_opdata2_i(ex_op2),
    .flush_i(flush), .stall_hold_i(stall_hold),
    .stallreq_o(stallreq_o), .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
    .div_result_i(div_result), .div_ready_i(div_ready),
    .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .timeout_o(timeout_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '0; r = '0;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a; r = '0;
      end else begin
        q = 32'($signed(a) / $signed(b));
        r = 32'($signed(a) % $signed(b));
      end
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  // Runs at each negedge: launches on a start it sees, answers after dm_lat cycles.
  task automatic dm_update();
    div_ready  = 1'b0;
    div_result = {$urandom, $urandom};
    if (dm_wait_low && !div_start_o) dm_wait_low = 0;
    if (!dm_busy && !dm_wait_low && div_start_o) begin
      dm_busy = 1;
      dm_cnt  = dm_lat;
      dm_res  = ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);
    end else if (dm_busy && !dm_hang) begin
      dm_cnt--;
      if (dm_cnt == 0) begin
        div_ready   = 1'b1;
        div_result  = dm_res;
        dm_busy     = 0;
        dm_wait_low = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    dm_update();
  endtask

  task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_v, input int hold_n, input int lat);
    bit got_ready, done;
    int holds;
    dm_lat = lat;
    exp_q.push_back(exp_v);
    got_ready = 0; done = 0; holds = hold_n;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      ex_req = 1'b1; flush = 1'b0;
      if (cyc == 0) begin
        ex_signed = sg; ex_op1 = a; ex_op2 = b;
      end else begin
        ex_signed = 1'($urandom_range(0, 1)); ex_op1 = $urandom; ex_op2 = $urandom;
      end
      stall_hold = got_ready && holds > 0;
      #1;
      if (cyc == 0) check_eq("start_low_before_issue", div_start_o, 1'b0);
      if (!got_ready) begin
        check_eq("stallreq_busy", stallreq_o, 1'b1);
        check_eq("whilo_busy", whilo_o, 1'b0);
        if (cyc > 0) begin
          check_eq("start_held", div_start_o, 1'b1);
          check_eq("opdata1_held", div_opdata1_o, a);
          check_eq("opdata2_held", div_opdata2_o, b);
          check_eq("signed_held", div_signed_o, sg);
        end
      end else begin
        check_eq("stallreq_done", stallreq_o, 1'b0);
        check_eq("start_low_after_ready", div_start_o, 1'b0);
        check_eq("whilo_done", whilo_o, holds == 0);
        if (holds == 0) done = 1;
        else holds--;
      end
      if (div_ready) got_ready = 1;
      step();
    end
    check_eq("div_complete", done, 1'b1);
    last_hilo = exp_v;
    ex_req = 1'b0; stall_hold = 1'b0;
  endtask

  // same=1 flushes in the ready cycle; otherwise flushes at cycle flush_at and then
  // presents a new request while the divider drains.
  task automatic do_flush(input bit same, input int flush_at, input int lat);
    logic [31:0] a, b;
    logic        sg;
    bit          flushed, done;
    a = $urandom; b = $urandom_range(1, 1000); sg = 1'($urandom_range(0, 1));
    dm_lat = lat; flushed = 0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      ex_req = 1'b1; stall_hold = 1'b0;
      if (!flushed) begin
        if (cyc == 0) begin
          ex_signed = sg; ex_op1 = a; ex_op2 = b;
        end else begin
          ex_op1 = $urandom; ex_op2 = $urandom;
        end
        flush = same ? div_ready : (cyc == flush_at);
        #1;
        check_eq("flush_stallreq", stallreq_o, 1'b1);
        check_eq("flush_whilo", whilo_o, 1'b0);
        if (cyc > 0) begin
          check_eq("flush_start_held", div_start_o, 1'b1);
          check_eq("flush_opdata1_held", div_opdata1_o, a);
        end
        if (flush) begin
          flushed = 1;
          if (div_ready) done = 1;
        end
      end else begin
        ex_op1 = $urandom; ex_op2 = $urandom;
        flush = 1'($urandom_range(0, 1));
        #1;
        check_eq("drain_start_held", div_start_o, 1'b1);
        check_eq("drain_stallreq", stallreq_o, 1'b1);
        check_eq("drain_whilo", whilo_o, 1'b0);
        if (div_ready) done = 1;
      end
      step();
    end
    check_eq("flush_complete", done, 1'b1);
    flush = 1'b0;
  endtask

  // Idle cycles with stray ready pulses and flushed requests: nothing may happen.
  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_req = 1'($urandom_range(0, 1)); flush = ex_req; stall_hold = 1'($urandom_range(0, 1));
      ex_op1 = $urandom; ex_op2 = $urandom;
      div_ready = 1'($urandom_range(0, 1)); div_result = {$urandom, $urandom};
      #1;
      check_eq("idle_stallreq", stallreq_o, 1'b0);
      check_eq("idle_start", div_start_o, 1'b0);
      check_eq("idle_hilo", {hi_o, lo_o}, last_hilo);
      step();
    end
    ex_req = 1'b0; flush = 1'b0; stall_hold = 1'b0;
  endtask

  task automatic do_timeout();
    dm_hang = 1; dm_lat = 1;
    for (int cyc = 0; cyc <= TO; cyc++) begin
      ex_req = 1'b1; ex_signed = 1'b0; flush = 1'b0;
      ex_op1 = (cyc == 0) ? 32'd50 : $urandom; ex_op2 = 32'd5;
      #1;
      check_eq("timeout_early", timeout_o, 1'b0);
      check_eq("timeout_stallreq", stallreq_o, 1'b1);
      if (cyc > 0) check_eq("timeout_start_held", div_start_o, 1'b1);
      step();
    end
    ex_req = 1'b0;
    #1;
    check_eq("timeout_flag", timeout_o, 1'b1);
    check_eq("timeout_start_low", div_start_o, 1'b0);
    check_eq("timeout_state_idle", state_o, 2'd0);
    check_eq("timeout_whilo", whilo_o, 1'b0);
    dm_hang = 0; dm_busy = 0; dm_wait_low = 0;
    step();
  endtask

  always @(negedge clk) begin
    logic [63:0] exp_w;
    #2;
    if (rst && whilo_o) begin
      if (exp_q.size() == 0) check_eq("spurious_whilo", whilo_o, 1'b0);
      else begin
        exp_w = exp_q.pop_front();
        check_eq("hilo_write", {hi_o, lo_o}, exp_w);
      end
    end
  end

  initial begin
    logic        sg;
    logic [31:0] a, b;
    int          lat;
    rst = 1'b0; ex_req = 1'b0; ex_signed = 1'b0; ex_op1 = '0; ex_op2 = '0;
    flush = 1'b0; stall_hold = 1'b0; div_ready = 1'b0; div_result = '0;
    dm_busy = 0; dm_hang = 0; dm_wait_low = 0; dm_cnt = 0; dm_lat = 1; dm_res = '0;
    last_hilo = '0;
    @(negedge clk); #1;
    check_eq("rst_start", div_start_o, 1'b0);
    check_eq("rst_signed", div_signed_o, 1'b0);
    check_eq("rst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
    check_eq("rst_whilo", whilo_o, 1'b0);
    check_eq("rst_timeout", timeout_o, 1'b0);
    check_eq("rst_state", state_o, 2'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 3);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 5);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 3, 4);
    do_div(1'b0, 32'd12345, 32'd0, 64'd0, 0, 2);
    do_idle(4);
    do_flush(0, 2, 8);
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1, 3);
    do_flush(1, 0, 4);
    do_div(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 0, 1);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        lat = $urandom_range(2, 10);
        do_flush(1'($urandom_range(0, 1)), $urandom_range(1, lat), lat);
      end
      sg = 1'($urandom_range(0, 1));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = -$urandom_range(1, 16);
        default: b = $urandom;
      endcase
      do_div(sg, a, b, ref_div(sg, a, b), $urandom_range(0, 3), $urandom_range(1, 10));
      if ($urandom_range(0, 2) == 0) do_idle($urandom_range(1, 3));
    end

    do_timeout();
    do_div(1'b0, 32'd77, 32'd7, {32'd0, 32'd11}, 0, 2);
    check_eq("timeout_sticky", timeout_o, 1'b1);

    // async reset in the middle of a divide
    ex_req = 1'b1; ex_signed = 1'b1; ex_op1 = 32'd999; ex_op2 = 32'd4; dm_lat = 20;
    step(); step(); step();
    ex_req = 1'b0;
    #3 rst = 1'b0;
    #1;
    check_eq("arst_start", div_start_o, 1'b0);
    check_eq("arst_signed", div_signed_o, 1'b0);
    check_eq("arst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
    check_eq("arst_hilo", {hi_o, lo_o}, 64'd0);
    check_eq("arst_timeout", timeout_o, 1'b0);
    check_eq("arst_whilo", whilo_o, 1'b0);
    check_eq("arst_stallreq", stallreq_o, 1'b0);
    check_eq("arst_state", state_o, 2'd0);
    dm_busy = 0; dm_wait_low = 0; div_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_hilo = '0;
    do_idle(2);
    do_div(1'b0, 32'd64, 32'd8, {32'd0, 32'd8}, 2, 6);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
